// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, absolute jumps, relative branches,
// jump-register with operand wait, one-cycle wrong-path flush and a halt state.
module pc_sequencer #(
   parameter logic [12:0] RESET_PC = 13'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        resume,
   input  logic        jump_req,
   input  logic [12:0] jump_target,
   input  logic        br_req,
   input  logic        br_taken,
   input  logic [7:0]  br_offset,
   input  logic        jr_req,
   input  logic [15:0] reg_out1,
   input  logic        reg_valid,
   output logic [12:0] pc,
   output logic        jr_sel,
   output logic        flush,
   output logic        halted,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_REG = 2'd1,
      FLUSH    = 2'd2,
      HALT     = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic [12:0] pc_reg, pc_next;
   logic [12:0] br_target;
   logic        unused_reg_bits;

   // Only 13 bits of the register operand address the program space.
   assign unused_reg_bits = ^reg_out1[15:13];

   assign br_target = pc_reg + 13'd1 + {{5{br_offset[7]}}, br_offset};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         RUN: begin
            if (!stall) begin
               if (jr_req) begin
                  if (reg_valid) begin
                     pc_next    = reg_out1[12:0];
                     state_next = FLUSH;
                  end else begin
                     state_next = WAIT_REG;
                  end
               end else if (jump_req) begin
                  pc_next    = jump_target;
                  state_next = FLUSH;
               end else if (br_req && br_taken) begin
                  pc_next    = br_target;
                  state_next = FLUSH;
               end else if (halt_req) begin
                  state_next = HALT;
               end else begin
                  pc_next = pc_reg + 13'd1;
               end
            end
         end
         WAIT_REG: begin
            if (reg_valid) begin
               pc_next    = reg_out1[12:0];
               state_next = FLUSH;
            end
         end
         FLUSH: state_next = RUN;
         HALT: begin
            if (resume) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   assign pc     = pc_reg;
   assign state  = state_reg;
   assign flush  = (state_reg == FLUSH);
   assign halted = (state_reg == HALT);
   // Mux select is combinational so the register source is chosen in the request cycle.
   assign jr_sel = !rst && ((state_reg == WAIT_REG) ||
                            (state_reg == RUN && !stall && jr_req));

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

   localparam logic [12:0] RST_PC = 13'h0000;

   logic        clk = 1'b0;
   logic        rst, stall, halt_req, resume, jump_req, br_req, br_taken, jr_req, reg_valid;
   logic [12:0] jump_target;
   logic [7:0]  br_offset;
   logic [15:0] reg_out1;
   logic [12:0] pc;
   logic        jr_sel, flush, halted;
   logic [1:0]  state;

   int tests = 0;
   int fails = 0;
   int m_pc = 0;
   int m_st = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
      .jump_req(jump_req), .jump_target(jump_target), .br_req(br_req),
      .br_taken(br_taken), .br_offset(br_offset), .jr_req(jr_req),
      .reg_out1(reg_out1), .reg_valid(reg_valid), .pc(pc), .jr_sel(jr_sel),
      .flush(flush), .halted(halted), .state(state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      rst = 0; stall = 0; halt_req = 0; resume = 0; jump_req = 0; jump_target = 0;
      br_req = 0; br_taken = 0; br_offset = 0; jr_req = 0; reg_out1 = 0; reg_valid = 0;
   endtask

   function automatic int wrap(input int v);
      return ((v % 8192) + 8192) % 8192;
   endfunction

   // Apply current inputs for one clock and compare everything against the model.
   task automatic cyc();
      int exp_sel;
      #1;
      exp_sel = (!rst && (m_st == 1 || (m_st == 0 && !stall && jr_req))) ? 1 : 0;
      check("jr_sel", {31'd0, jr_sel}, exp_sel);
      if (rst) begin
         m_pc = RST_PC; m_st = 0;
      end else if (m_st == 0) begin
         if (!stall) begin
            if (jr_req && reg_valid) begin m_pc = reg_out1 % 8192; m_st = 2; end
            else if (jr_req)         m_st = 1;
            else if (jump_req)       begin m_pc = jump_target; m_st = 2; end
            else if (br_req && br_taken) begin
               m_pc = wrap(m_pc + 1 + int'($signed(br_offset))); m_st = 2;
            end
            else if (halt_req)       m_st = 3;
            else                     m_pc = wrap(m_pc + 1);
         end
      end else if (m_st == 1) begin
         if (reg_valid) begin m_pc = reg_out1 % 8192; m_st = 2; end
      end else if (m_st == 2) begin
         m_st = 0;
      end else if (resume) begin
         m_st = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check("pc", pc, m_pc);
      check("state", state, m_st);
      check("flush", flush, (m_st == 2) ? 1 : 0);
      check("halted", halted, (m_st == 3) ? 1 : 0);
      $display("[TB] t=%0t pc=%0h state=%0d flush=%0b halted=%0b", $time, pc, state, flush, halted);
   endtask

   task automatic goto_pc(input logic [12:0] t);
      clear_inputs(); jump_req = 1; jump_target = t; cyc();
      clear_inputs(); cyc();
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);
      rst = 1; cyc(); cyc();
      rst = 0;
      check("rst_pc", pc, RST_PC);
      check("rst_state", state, 0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("idle_pc", pc, i);
      end

      // Backward taken branch
      goto_pc(13'h0010);
      br_req = 1; br_taken = 1; br_offset = 8'hFC; cyc();
      check("br_pc", pc, 13'h000D);
      check("br_flush", flush, 1);
      clear_inputs(); cyc(); cyc();
      check("br_seq", pc, 13'h000E);

      // Jump-register waiting on the operand
      goto_pc(13'h0020);
      jr_req = 1; cyc();
      clear_inputs(); cyc();
      check("jr_wait_pc", pc, 13'h0020);
      check("jr_wait_st", state, 1);
      reg_valid = 1; reg_out1 = 16'hE123; cyc();
      check("jr_pc", pc, 13'h0123);
      clear_inputs(); cyc();

      // Simultaneous requests: jump-register wins
      jr_req = 1; reg_valid = 1; reg_out1 = 16'h0040; jump_req = 1;
      jump_target = 13'h0100; halt_req = 1; cyc();
      check("prio_pc", pc, 13'h0040);
      clear_inputs(); cyc();

      // Wrap, halt with stall toggling, resume
      goto_pc(13'h1FFF);
      cyc();
      check("wrap_pc", pc, 13'h0000);
      halt_req = 1; cyc();
      check("halted", halted, 1);
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         stall = i[0]; cyc();
         check("halt_pc", pc, 13'h0000);
      end
      clear_inputs(); resume = 1; cyc();
      clear_inputs(); cyc();
      check("resume_pc", pc, 13'h0001);

      // Reset out of WAIT_REG and HALT
      jr_req = 1; cyc();
      clear_inputs(); rst = 1; cyc();
      check("rst_wait_st", state, 0);
      clear_inputs(); halt_req = 1; cyc();
      clear_inputs(); rst = 1; cyc();
      check("rst_halt_pc", pc, RST_PC);
      clear_inputs();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 99) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         halt_req    = ($urandom_range(0, 9) == 0);
         resume      = ($urandom_range(0, 3) == 0);
         jump_req    = ($urandom_range(0, 9) == 0);
         jump_target = 13'($urandom);
         br_req      = ($urandom_range(0, 5) == 0);
         br_taken    = $urandom_range(0, 1) == 1;
         br_offset   = 8'($urandom);
         jr_req      = ($urandom_range(0, 11) == 0);
         reg_out1    = 16'($urandom);
         reg_valid   = $urandom_range(0, 1) == 1;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
